// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bridge_pkg
// Description : Shared encodings for the AHB-to-APB bridge AHB-side front end.
// Revision    : 1.0 - initial release
// ============================================================================
package bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HSIZE_BYTE      = 3'b000;
    localparam logic [2:0] HSIZE_HALF_WORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD      = 3'b010;

    localparam int CTRL_WIDTH    = 41;
    localparam int CW_HWRITE     = 40;
    localparam int CW_HTRANS_MSB = 39;
    localparam int CW_HTRANS_LSB = 38;
    localparam int CW_HBURST_MSB = 37;
    localparam int CW_HBURST_LSB = 35;
    localparam int CW_HSIZE_MSB  = 34;
    localparam int CW_HSIZE_LSB  = 32;
    localparam int CW_HADDR_MSB  = 31;
    localparam int CW_HADDR_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_PUSH = 3'd1,
        ST_R_PUSH = 3'd2,
        ST_R_WAIT = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_xfer_check.sv
`default_nettype none
// ============================================================================
// Module      : ahb_xfer_check
// Description : Flags unsupported sizes and misaligned addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_xfer_check
    import bridge_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] haddr_lo_i,
    output logic       illegal_o
);

    always_comb begin
        illegal_o = 1'b0;
        if (hsize_i > HSIZE_WORD)
            illegal_o = 1'b1;
        else if (hsize_i == HSIZE_HALF_WORD && haddr_lo_i[0])
            illegal_o = 1'b1;
        else if (hsize_i == HSIZE_WORD && haddr_lo_i != 2'b00)
            illegal_o = 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/ahb_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_fsm
// Description : AHB-Lite slave front end; packs transfers into control words
//               and moves data to/from the bridge data FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_fsm
    import bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit ERR_EN     = 1'b1
) (
    input  logic                  hclk,
    input  logic                  reset,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hreadyin,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  ctrl_wen,
    output logic [CTRL_WIDTH-1:0] ctrl_wdata,
    input  logic                  ctrl_full,
    output logic                  ahb_data_wen,
    output logic [DATA_WIDTH-1:0] ahb_data_wdata,
    input  logic                  ahb_data_full,
    output logic                  apb_data_ren,
    input  logic [DATA_WIDTH-1:0] apb_data_read,
    input  logic                  apb_data_empty
);

    state_t                  state_q;
    logic [31:0]             haddr_q;
    logic                    hwrite_q;
    logic [1:0]              htrans_q;
    logic [2:0]              hsize_q;
    logic [2:0]              hburst_q;
    logic [DATA_WIDTH-1:0]   hrdata_q;

    logic w_accept;
    logic w_chk_illegal;
    logic w_illegal;
    logic w_wr_ok;
    logic w_rd_push_ok;
    logic w_pop_ok;

    ahb_xfer_check u_xfer_check (
        .hsize_i    (hsize),
        .haddr_lo_i (haddr[1:0]),
        .illegal_o  (w_chk_illegal)
    );

    assign w_illegal    = ERR_EN ? w_chk_illegal : 1'b0;
    assign w_accept     = (state_q == ST_IDLE) && hsel && hreadyin && htrans[1];
    assign w_wr_ok      = (state_q == ST_W_PUSH) && !ctrl_full && !ahb_data_full;
    assign w_rd_push_ok = (state_q == ST_R_PUSH) && !ctrl_full;
    assign w_pop_ok     = (state_q == ST_R_WAIT) && !apb_data_empty;

    // Strobes are masked by reset so a FIFO-full release coinciding with reset never pushes.
    assign ctrl_wen       = (w_wr_ok || w_rd_push_ok) && !reset;
    assign ahb_data_wen   = w_wr_ok && !reset;
    assign apb_data_ren   = w_pop_ok && !reset;
    assign ahb_data_wdata = hwdata;

    assign hreadyout = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign hrdata    = hrdata_q;
    assign ctrl_wdata = {hwrite_q, htrans_q, hburst_q, hsize_q, haddr_q};

    always_ff @(posedge hclk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            htrans_q <= '0;
            hsize_q  <= '0;
            hburst_q <= '0;
            hrdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        haddr_q  <= haddr;
                        hwrite_q <= hwrite;
                        htrans_q <= htrans;
                        hsize_q  <= hsize;
                        hburst_q <= hburst;
                        if (w_illegal)
                            state_q <= ST_ERR1;
                        else if (hwrite)
                            state_q <= ST_W_PUSH;
                        else
                            state_q <= ST_R_PUSH;
                    end
                end
                ST_W_PUSH: if (w_wr_ok) state_q <= ST_IDLE;
                ST_R_PUSH: if (w_rd_push_ok) state_q <= ST_R_WAIT;
                ST_R_WAIT: begin
                    if (w_pop_ok) begin
                        hrdata_q <= apb_data_read;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_ERR1: state_q <= ST_ERR2;
                ST_ERR2: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ahb_slave_fsm.md
Name: ahb_slave_fsm

Overview:
- AHB-Lite slave front end of the AHB-to-APB bridge, upstream of the APB-side FSM.
- Accepts AHB address and data phases and packs each valid transfer into a 41-bit control word for the control FIFO.
- Pushes write data into the AHB data FIFO and pops read data from the APB data FIFO to return on hrdata.
- Stalls the bus with hreadyout and issues two-cycle ERROR responses for unsupported transfers.

Parameters:
- DATA_WIDTH, 32, width of hwdata/hrdata and of both data FIFOs.
- ERR_EN, 1, 1 = unsupported hsize or misaligned address gets an ERROR response; 0 = the transfer is forwarded as-is.

Ports:
- hclk  in  1  bridge clock (AHB domain).
- reset  in  1  synchronous, active-high reset.
- hsel  in  1  slave select.
- haddr  in  32  address.
- htrans  in  2  transfer type.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size.
- hburst  in  3  burst type, passed through only.
- hwdata  in  DATA_WIDTH  write data.
- hreadyin  in  1  bus-level HREADY.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  DATA_WIDTH  read data.
- ctrl_wen  out  1  control FIFO push.
- ctrl_wdata  out  41  control word.
- ctrl_full  in  1  control FIFO full.
- ahb_data_wen  out  1  write-data FIFO push.
- ahb_data_wdata  out  DATA_WIDTH  write data.
- ahb_data_full  in  1  write-data FIFO full.
- apb_data_ren  out  1  read-data FIFO pop (first-word-fall-through FIFO).
- apb_data_read  in  DATA_WIDTH  read-data FIFO head.
- apb_data_empty  in  1  read-data FIFO empty.

Behaviour:
- Control word layout:
  - [40] hwrite
  - [39:38] htrans
  - [37:35] hburst
  - [34:32] hsize
  - [31:0] haddr
- Address-phase acceptance ("accept"): state IDLE & hsel & hreadyin & htrans[1] (NSEQ or SEQ).
- On accept, haddr/hwrite/hsize/hburst/htrans are registered into holding registers; ctrl_wdata is driven from those registers.
- htrans IDLE or BUSY, or hsel=0: no action, state stays IDLE, zero-wait OKAY.
- Illegal transfer (only when ERR_EN=1): hsize > WORD; HALF_WORD with haddr[0]=1; WORD with haddr[1:0]!=0. Checked at accept.
- States and transitions:
  - IDLE: accept -> W_PUSH (write), R_PUSH (read), or ERR1 (illegal).
  - W_PUSH: if !ctrl_full & !ahb_data_full, push and go to IDLE; else hold.
  - R_PUSH: if !ctrl_full, push and go to R_WAIT; else hold.
  - R_WAIT: if !apb_data_empty, pop and go to IDLE; else hold.
  - ERR1 -> ERR2 -> IDLE unconditionally.
- Outputs:
  - hreadyout = 1 in IDLE and ERR2, 0 in all other states (combinational state decode).
  - hresp = 1 in ERR1 and ERR2, else 0.
  - ctrl_wen = (W_PUSH & !ctrl_full & !ahb_data_full) | (R_PUSH & !ctrl_full).
  - ahb_data_wen = W_PUSH & !ctrl_full & !ahb_data_full. ahb_data_wdata = hwdata, which AHB holds stable while hreadyout=0.
  - The control word and write data are always pushed in the same cycle; a push never occurs while either FIFO is full.
  - apb_data_ren = R_WAIT & !apb_data_empty.
  - hrdata is a register loaded with apb_data_read in the pop cycle and held until the next pop.
- Latency:
  - Write: hreadyout low for 1 cycle plus the number of full cycles.
  - Read: 1 push cycle plus one cycle per R_WAIT cycle (at least 1).
- Pipelining: the next transfer's address phase is sampled in the IDLE cycle where the previous data phase completes.
- Reset: state goes to IDLE and all holding registers and hrdata clear to 0, so after reset hreadyout=1, hresp=0, all wen/ren=0.
- Reset mid-transfer: the in-flight transfer is abandoned with no partial push. The FIFOs share the same reset.
- Simultaneous FIFO-full deassertion and reset: reset wins, no push.

Decomposition:
- Shared package bridge_pkg holds:
  - htrans encodings (IDLE 2'b00, BUSY 2'b01, NSEQ 2'b10, SEQ 2'b11)
  - hsize encodings (BYTE 3'b000, HALF_WORD 3'b001, WORD 3'b010)
  - control-word field positions
  - state encodings
  - CTRL_WIDTH = 41
- One combinational sub-module, ahb_xfer_check: from hsize and haddr[1:0], outputs illegal.

Test Plan:
- Write NSEQ, haddr 0x0000_1004, WORD, hwdata 0xDEADBEEF, FIFOs empty -> 1 wait cycle; ctrl_wen=ahb_data_wen=1 in the same cycle; ctrl_wdata = {1,2'b10,3'b000,3'b010,0x00001004}; OKAY.
- Read of 0x20, apb_data_empty held high 5 cycles, then head 0x12345678 -> ctrl_wen pulses once; hreadyout=0 until the pop cycle; hrdata=0x12345678 with hreadyout=1.
- Write with ahb_data_full=1 for 3 cycles -> hreadyout low 4 cycles; no wen until full drops; exactly one push.
- WORD at haddr 0x2 (ERR_EN=1) -> hresp=1 for 2 cycles with hreadyout 0 then 1; no FIFO push.
- Back-to-back write 0x0, read 0x4 -> second address sampled on the first's completing cycle; control words pushed in order W then R.
- reset asserted in R_WAIT -> next cycle IDLE, hreadyout=1, hrdata=0, apb_data_ren never pulses.
